touch_adc_spi_master: RTL and testbench
=======================================

# touch_adc_spi_master

Avalon-MM slave that drives the serial command/readback transaction to the touch-panel ADC (ADS7843-class, 8-bit command + 12-bit result, SPI mode 0). Software writes a command byte, the block clocks it out on DIN, captures the 12-bit conversion from DOUT, and raises a maskable completion interrupt. It sits beside the pen-down interrupt input port on the same system interconnect. The pen-down input signals a touch; this block performs the follow-up coordinate read.

## Interface
- CLK_DIV, 25: system clocks per DCLK half-period; legal range is ≥2. With the default and a 50 MHz `clk`, DCLK is 1 MHz.
- clk  in  1  system clock; all logic is on the rising edge.
- reset_n  in  1  asynchronous active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- irq  out  1  completion interrupt; level, combinational from registers.
- spi_cs_n  out  1  ADC chip select, active low.
- spi_dclk  out  1  ADC serial clock; idles low.
- spi_din  out  1  command bits to the ADC, MSB first.
- spi_dout  in  1  conversion data from the ADC; passes through a 2-flop synchronizer before use.

## Operation
Register map; a write takes effect when `chipselect && !write_n` on the clock edge.
- Address 0:
  - Write bits [7:0]: command byte. Starts a transaction only in IDLE; a write while busy is ignored, with no state change.
  - Read: {20'b0, result[11:0]}.
- Address 1:
  - Read: {30'b0, done, busy}.
  - Any write clears `done`.
- Address 2: `irq_mask[0]`, read/write.
- Address 3: reads 0; writes are ignored.
- `readdata` is registered every cycle from `address` (one-cycle read latency) and is independent of `chipselect`.
- `irq = done & irq_mask`.
- State machine:
  - IDLE: `cs_n`=1, `dclk`=0, `din`=0. A command write loads the shift register and goes to SETUP.
  - SETUP: `cs_n`=0, `din`=cmd[7]. Lasts CLK_DIV cycles, then goes to SHIFT.
  - SHIFT: 24 DCLK periods.
    - `dclk` toggles every CLK_DIV cycles.
    - On each falling edge, `din` shifts to the next command bit; after bit 0 it drives 0.
    - On rising edges 10..21 (counting from 1), the synchronized `dout` is shifted into `result`, MSB first.
    - After the 24th falling edge, go to HOLD.
  - HOLD: `cs_n`=0, `dclk`=0 for CLK_DIV cycles. Then `cs_n` goes to 1, the captured value is written to `result`, `done` is set, and the state returns to IDLE, all on the same edge.
- `busy` = (state != IDLE).
- `result` holds its previous value until a transaction completes.
- A new command write does not clear `done`; software clears it through address 1.

## Timing
- Reset values: `readdata`=0, `irq`=0, `spi_cs_n`=1, `spi_dclk`=0, `spi_din`=0, `result`=0, `done`=0, `irq_mask`=0, state IDLE.
- Command write accepted at edge T:
  - `spi_cs_n`=0 and `busy`=1 are visible after edge T.
  - The first `dclk` rise occurs at T+CLK_DIV.
  - `done`=1 and `spi_cs_n`=1 occur at T+50·CLK_DIV.
- DCLK high and low phases are each exactly CLK_DIV cycles; there is no jitter.
- `din` changes only on DCLK falling edges, or at SETUP entry. It is stable across every rising edge.
- `dout` sampling uses the synchronized value, which adds 2 cycles of delay. This is valid because CLK_DIV ≥ 2 ≤ half-period.
- Completion and a write-clear of `done` in the same cycle: set wins.
- Completion and a new command write in the same cycle: the write is ignored (still busy).
- Reset mid-transaction: all outputs go to reset values immediately. The partial result is discarded.

## Structure
- Shared package `touch_adc_pkg`:
  - register address constants (ADDR_CMD_RESULT=0, ADDR_STATUS=1, ADDR_MASK=2)
  - state enum {IDLE, SETUP, SHIFT, HOLD}
  - constants NUM_DCLK=24, RES_FIRST_EDGE=10, RES_BITS=12
- Sub-module `spi_tick_gen`:
  - counts 0..CLK_DIV-1 while enabled and emits a one-cycle `tick` at the terminal count
  - restarts from 0 on enable rise
- Top-level contents: register file, FSM, edge counter (5 bits), shift registers.

## Test plan
- Reset, then read addresses 0–3: all return 0. `spi_cs_n`=1, `irq`=0.
- CLK_DIV=2, write cmd 0x93; the ADC model returns 0xA5C:
  - `din` shows 1,0,0,1,0,0,1,1 on rising edges 1–8.
  - `done` rises exactly 100 cycles after the write edge.
  - A read of address 0 returns 0x00000A5C.
- Set irq_mask=1 and run a transaction: `irq` rises with `done`. A write to address 1 drops `irq` the next cycle.
- Write cmd 0xD0 mid-transaction (cycle 40): no effect, and the original command completes unchanged. Also force a clear-write in the same cycle as completion: `done` stays 1.
- Assert reset_n=0 at cycle 30 of a transaction: `spi_cs_n`=1 and `spi_dclk`=0 immediately. After release, `busy`=0 and `result`=0.

Source files
------------

// File: rtl/touch_adc_spi_master_pkg.sv
// Shared definitions for the touch-panel ADC serial master: register map,
// controller states and transaction geometry.
package touch_adc_pkg;

  localparam logic [1:0] ADDR_CMD_RESULT = 2'd0;
  localparam logic [1:0] ADDR_STATUS     = 2'd1;
  localparam logic [1:0] ADDR_MASK       = 2'd2;

  localparam int NUM_DCLK       = 24;
  localparam int RES_FIRST_EDGE = 10;
  localparam int RES_BITS       = 12;
  localparam int EDGE_W         = 5;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

  // Rising DCLK edges (counted from 1) that carry conversion bits.
  function automatic logic in_result_window(input logic [EDGE_W-1:0] rise);
    return (rise >= EDGE_W'(RES_FIRST_EDGE)) &&
           (rise <  EDGE_W'(RES_FIRST_EDGE + RES_BITS));
  endfunction

endpackage

// File: rtl/touch_adc_spi_master_if.sv
// Avalon-MM register port of the touch ADC master, including its interrupt.
interface touch_adc_spi_master_if;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        irq;

  modport master (output address, chipselect, write_n, writedata,
                  input  readdata, irq);
  modport slave  (input  address, chipselect, write_n, writedata,
                  output readdata, irq);
endinterface

// File: rtl/touch_adc_spi_master_tick_gen.sv
// Free-running divider that pulses tick every CLK_DIV cycles while enabled;
// held at zero when disabled so each enable starts a full interval.
module spi_tick_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  output logic tick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] cnt_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_reg <= '0;
    end else if (!en || cnt_reg == LAST) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign tick = en && (cnt_reg == LAST);

endmodule

// File: rtl/touch_adc_spi_master.sv
// Register-driven command/readback sequencer for an ADS7843-class touch ADC
// (8-bit command out, 12-bit conversion in, SPI mode 0).
module touch_adc_spi_master
  import touch_adc_pkg::*;
#(
  parameter int CLK_DIV = 25
) (
  input  logic                    clk,
  input  logic                    reset_n,
  touch_adc_spi_master_if.slave   bus,
  output logic                    spi_cs_n,
  output logic                    spi_dclk,
  output logic                    spi_din,
  input  logic                    spi_dout
);

  state_t              state_reg;
  logic [7:0]          cmd_shift_reg;
  logic [RES_BITS-1:0] res_shift_reg;
  logic [RES_BITS-1:0] result_reg;
  logic [EDGE_W-1:0]   edge_cnt_reg;
  logic [1:0]          dout_sync_reg;
  logic                done_reg;
  logic                irq_mask_reg;
  logic                cs_n_reg;
  logic                dclk_reg;
  logic                din_reg;
  logic [31:0]         readdata_reg;

  logic                wr_en;
  logic                busy;
  logic                tick;
  logic [EDGE_W-1:0]   next_rise;
  logic                unused_wdata;

  assign wr_en        = bus.chipselect && !bus.write_n;
  assign busy         = (state_reg != IDLE);
  assign next_rise    = edge_cnt_reg + 1'b1;
  assign unused_wdata = ^bus.writedata[31:8];

  spi_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (busy),
    .tick    (tick)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_sync_reg <= '0;
    end else begin
      dout_sync_reg <= {dout_sync_reg[0], spi_dout};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      cmd_shift_reg <= '0;
      res_shift_reg <= '0;
      result_reg    <= '0;
      edge_cnt_reg  <= '0;
      done_reg      <= 1'b0;
      irq_mask_reg  <= 1'b0;
      cs_n_reg      <= 1'b1;
      dclk_reg      <= 1'b0;
      din_reg       <= 1'b0;
    end else begin
      if (wr_en && bus.address == ADDR_STATUS) begin
        done_reg <= 1'b0;
      end
      if (wr_en && bus.address == ADDR_MASK) begin
        irq_mask_reg <= bus.writedata[0];
      end

      // Completion's done set is assigned later, so it wins over a clear.
      case (state_reg)
        IDLE: begin
          if (wr_en && bus.address == ADDR_CMD_RESULT) begin
            state_reg     <= SETUP;
            cs_n_reg      <= 1'b0;
            din_reg       <= bus.writedata[7];
            cmd_shift_reg <= {bus.writedata[6:0], 1'b0};
            res_shift_reg <= '0;
            edge_cnt_reg  <= '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state_reg    <= SHIFT;
            dclk_reg     <= 1'b1;
            edge_cnt_reg <= next_rise;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (dclk_reg) begin
              dclk_reg      <= 1'b0;
              din_reg       <= cmd_shift_reg[7];
              cmd_shift_reg <= {cmd_shift_reg[6:0], 1'b0};
            end else if (edge_cnt_reg == EDGE_W'(NUM_DCLK)) begin
              // Low phase after the last falling edge has run its course.
              state_reg <= HOLD;
            end else begin
              dclk_reg     <= 1'b1;
              edge_cnt_reg <= next_rise;
              if (in_result_window(next_rise)) begin
                res_shift_reg <= {res_shift_reg[RES_BITS-2:0], dout_sync_reg[1]};
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_reg  <= IDLE;
            cs_n_reg   <= 1'b1;
            result_reg <= res_shift_reg;
            done_reg   <= 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata_reg <= '0;
    end else begin
      case (bus.address)
        ADDR_CMD_RESULT: readdata_reg <= {20'b0, result_reg};
        ADDR_STATUS:     readdata_reg <= {30'b0, done_reg, busy};
        ADDR_MASK:       readdata_reg <= {31'b0, irq_mask_reg};
        default:         readdata_reg <= '0;
      endcase
    end
  end

  assign bus.readdata = readdata_reg;
  assign bus.irq      = done_reg & irq_mask_reg;
  assign spi_cs_n     = cs_n_reg;
  assign spi_dclk     = dclk_reg;
  assign spi_din      = din_reg;

endmodule

// File: tb/tb_touch_adc_spi_master.sv
// Randomised scoreboard bench for touch_adc_spi_master with a behavioural ADC
// that presents each conversion bit ahead of the DCLK edge that samples it.
module tb_touch_adc_spi_master;
  import touch_adc_pkg::*;

  localparam int CLK_DIV    = 2;
  localparam int TXN_CYCLES = 50 * CLK_DIV;

  logic clk      = 1'b0;
  logic reset_n  = 1'b0;
  logic spi_dout = 1'b0;
  wire  spi_cs_n;
  wire  spi_dclk;
  wire  spi_din;

  touch_adc_spi_master_if bus ();

  touch_adc_spi_master #(.CLK_DIV(CLK_DIV)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .spi_cs_n (spi_cs_n),
    .spi_dclk (spi_dclk),
    .spi_din  (spi_din),
    .spi_dout (spi_dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  cmd;
    logic [11:0] val;
    int          start;
  } txn_t;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } rd_t;

  txn_t txn_q[$];
  rd_t  rd_q[$];

  int   vectors     = 0;
  int   miscompares = 0;
  int   cyc         = 0;
  logic rd_req      = 1'b0;
  logic rd_chk      = 1'b0;
  logic mask_model  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    rd_chk <= rd_req;
  end

  // ADC model: after rising edge r, present the bit sampled on rising edge r+1.
  int adc_rise = 0;
  int adc_nxt  = 0;
  initial begin
    forever begin
      @(posedge spi_dclk or negedge spi_cs_n);
      if (spi_dclk) begin
        adc_rise = adc_rise + 1;
        adc_nxt  = adc_rise + 1;
        if (adc_nxt >= RES_FIRST_EDGE && adc_nxt < RES_FIRST_EDGE + RES_BITS && txn_q.size() > 0)
          spi_dout = txn_q[0].val[RES_FIRST_EDGE + RES_BITS - 1 - adc_nxt];
        else
          spi_dout = 1'($urandom);
      end else begin
        adc_rise = 0;
      end
    end
  end

  // Monitor: read data, DIN at every DCLK rise, and transaction completion.
  logic prev_dclk = 1'b0;
  logic prev_cs_n = 1'b1;
  int   rise_k    = 0;
  rd_t  r_m;
  txn_t t_m;
  initial begin
    forever begin
      @(negedge clk);
      if (rd_chk) begin
        if (rd_q.size() == 0) begin
          vectors++; miscompares++;
          $display("FAIL rd_underflow: readdata 0x%0h with no expectation", bus.readdata);
        end else begin
          r_m = rd_q.pop_front();
          chk(r_m.name, bus.readdata, r_m.exp);
        end
      end
      if (reset_n) begin
        if (prev_cs_n && !spi_cs_n) rise_k = 0;
        if (!prev_dclk && spi_dclk && txn_q.size() > 0) begin
          rise_k = rise_k + 1;
          if (rise_k == 1)
            chk("first_rise_cycle", 32'(cyc - txn_q[0].start), 32'(CLK_DIV));
          if (rise_k <= 8)
            chk("din_cmd_bit", 32'(spi_din), 32'(txn_q[0].cmd[8 - rise_k]));
          else
            chk("din_zero", 32'(spi_din), 32'd0);
        end
        if (!prev_cs_n && spi_cs_n) begin
          if (txn_q.size() == 0) begin
            vectors++; miscompares++;
            $display("FAIL unexpected_txn: cs_n released with no command pending");
          end else begin
            t_m = txn_q.pop_front();
            chk("done_cycle", 32'(cyc - t_m.start), 32'(TXN_CYCLES));
            chk("rise_count", 32'(rise_k), 32'(NUM_DCLK));
            chk("irq_at_done", 32'(bus.irq), 32'(mask_model));
            $display("txn cmd=0x%02h adc=0x%03h start=%0d end=%0d", t_m.cmd, t_m.val, t_m.start, cyc);
          end
        end
      end
      prev_dclk = spi_dclk;
      prev_cs_n = spi_cs_n;
    end
  end

  task automatic wr(input logic [1:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address    = addr;
    bus.writedata  = data;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic rd(input logic [1:0] addr, input logic [31:0] exp, input string name);
    @(negedge clk);
    bus.address = addr;
    rd_q.push_back('{name, exp});
    rd_req = 1'b1;
    @(posedge clk);
    #1;
    rd_req = 1'b0;
  endtask

  task automatic start_txn(input logic [7:0] cmd, input logic [11:0] val, output int s);
    @(negedge clk);
    s = cyc + 1;
    txn_q.push_back('{cmd, val, s});
    bus.address    = ADDR_CMD_RESULT;
    bus.writedata  = {24'b0, cmd};
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
  endtask

  task automatic wait_done();
    int n = 0;
    while (txn_q.size() > 0 && n < TXN_CYCLES + 50) begin
      @(negedge clk);
      n++;
    end
    if (txn_q.size() > 0) begin
      vectors++; miscompares++;
      $display("FAIL txn_timeout: %0d transaction(s) still pending after %0d cycles", txn_q.size(), n);
      txn_q.delete();
    end
  endtask

  int          s;
  logic [7:0]  rcmd;
  logic [11:0] rval;
  logic        rmask;

  initial begin
    bus.address    = 2'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("rst_dclk", 32'(spi_dclk), 32'd0);
    chk("rst_din",  32'(spi_din),  32'd0);
    chk("rst_irq",  32'(bus.irq),  32'd0);
    chk("rst_readdata", bus.readdata, 32'd0);
    reset_n = 1'b1;
    for (int a = 0; a < 4; a++) rd(2'(a), 32'd0, "reset_read");

    // Directed: command 0x93, ADC returns 0xA5C.
    start_txn(8'h93, 12'hA5C, s);
    wait_done();
    rd(ADDR_CMD_RESULT, 32'h0000_0A5C, "result_a5c");
    rd(ADDR_STATUS, 32'h2, "status_done");
    wr(ADDR_STATUS, 32'h0);
    rd(ADDR_STATUS, 32'h0, "status_cleared");
    wr(2'd3, $urandom);
    rd(2'd3, 32'h0, "addr3_reads_zero");

    // Interrupt enabled: irq rises with done and drops after a clear write.
    wr(ADDR_MASK, 32'h1);
    mask_model = 1'b1;
    rd(ADDR_MASK, 32'h1, "mask_read");
    rval = 12'($urandom);
    start_txn(8'($urandom), rval, s);
    wait_done();
    rd(ADDR_CMD_RESULT, {20'b0, rval}, "result_irq_txn");
    wr(ADDR_STATUS, 32'h0);
    @(negedge clk);
    chk("irq_cleared", 32'(bus.irq), 32'd0);

    // Command write while busy is ignored.
    rval = 12'($urandom);
    start_txn(8'($urandom), rval, s);
    repeat (40) @(negedge clk);
    wr(ADDR_CMD_RESULT, 32'h0000_00D0);
    wait_done();
    rd(ADDR_CMD_RESULT, {20'b0, rval}, "result_after_ignored_cmd");

    // Clear-write on the completion edge: set wins.
    wr(ADDR_STATUS, 32'h0);
    rval = 12'($urandom);
    start_txn(8'($urandom), rval, s);
    while (cyc < s + TXN_CYCLES - 2) @(negedge clk);
    wr(ADDR_STATUS, 32'h0);
    wait_done();
    rd(ADDR_STATUS, 32'h2, "done_set_wins");
    rd(ADDR_CMD_RESULT, {20'b0, rval}, "result_collision_txn");

    // Randomised transactions with random interrupt mask.
    for (int i = 0; i < 4; i++) begin
      rmask = 1'($urandom);
      wr(ADDR_STATUS, 32'h0);
      wr(ADDR_MASK, {31'b0, rmask});
      mask_model = rmask;
      rcmd = 8'($urandom);
      rval = 12'($urandom);
      start_txn(rcmd, rval, s);
      wait_done();
      rd(ADDR_CMD_RESULT, {20'b0, rval}, "result_random");
      rd(ADDR_STATUS, 32'h2, "status_random");
    end

    // Reset in the middle of a transaction.
    start_txn(8'($urandom), 12'($urandom), s);
    while (cyc < s + 30) @(negedge clk);
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    txn_q.delete();
    #1;
    chk("midrst_cs_n", 32'(spi_cs_n), 32'd1);
    chk("midrst_dclk", 32'(spi_dclk), 32'd0);
    chk("midrst_din",  32'(spi_din),  32'd0);
    chk("midrst_irq",  32'(bus.irq),  32'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    mask_model = 1'b0;
    rd(ADDR_STATUS, 32'h0, "status_after_reset");
    rd(ADDR_CMD_RESULT, 32'h0, "result_after_reset");
    rd(ADDR_MASK, 32'h0, "mask_after_reset");

    // Recovery transaction after reset.
    rval = 12'($urandom);
    start_txn(8'($urandom), rval, s);
    wait_done();
    rd(ADDR_CMD_RESULT, {20'b0, rval}, "result_after_recovery");

    repeat (3) @(negedge clk);
    if (rd_q.size() != 0) begin
      vectors++; miscompares++;
      $display("FAIL rd_pending: %0d read expectation(s) never checked", rd_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
